// File: rtl/topk_select.sv
// Top-K selector: latches one frame of tagged samples and streams it through a
// K-slot sorted insertion chain, returning the K best entries in min or max mode.
module topk_select #(
    parameter int DW        = 32,
    parameter int K         = 3,
    parameter int BUS_WIDTH = 12,
    parameter int IW        = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mode,
    input  logic [DW-1:0]            din [BUS_WIDTH],
    input  logic [IW-1:0]            index_in [BUS_WIDTH],
    input  logic [BUS_WIDTH-1:0]     in_mask,
    output logic [DW-1:0]            dout [K],
    output logic [IW-1:0]            out_index [K],
    output logic [K-1:0]             out_slot_valid,
    output logic [$clog2(K+1)-1:0]   out_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);
    localparam int JW = $clog2(BUS_WIDTH);
    localparam int CW = $clog2(K+1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nxt;

    logic [DW-1:0]        din_q  [BUS_WIDTH];
    logic [IW-1:0]        idx_q  [BUS_WIDTH];
    logic [BUS_WIDTH-1:0] mask_q;
    logic                 mode_q;
    logic [JW-1:0]        j_q;

    logic [DW-1:0] slot_v [K];
    logic [IW-1:0] slot_i [K];
    logic [K-1:0]  slot_sv;
    logic [K-1:0]  better, prev_better;

    logic          accept, last;
    logic [DW-1:0] e_v;
    logic [IW-1:0] e_i;
    logic          e_m;

    assign accept = in_valid & in_ready;
    assign last   = (j_q == JW'(BUS_WIDTH-1));
    assign e_v    = din_q[j_q];
    assign e_i    = idx_q[j_q];
    assign e_m    = mask_q[j_q];

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SCAN;
            SCAN:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mask_q <= '0;
            mode_q <= 1'b0;
            j_q    <= '0;
            for (int i = 0; i < BUS_WIDTH; i++) begin
                din_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else if (accept) begin
            din_q  <= din;
            idx_q  <= index_in;
            mask_q <= in_mask;
            mode_q <= mode;
            j_q    <= '0;
        end else if (state == SCAN) begin
            j_q <= j_q + JW'(1);
        end
    end

    // Slots stay sorted, so "better" is monotonic across the chain: the first
    // better slot takes e, every later better slot takes its predecessor.
    always_comb begin
        prev_better = '0;
        for (int s = 0; s < K; s++) begin
            better[s] = !slot_sv[s] || (mode_q ? (e_v > slot_v[s]) : (e_v < slot_v[s]));
            if (s > 0) prev_better[s] = better[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || accept) begin
            slot_sv <= '0;
            for (int s = 0; s < K; s++) begin
                slot_v[s] <= '0;
                slot_i[s] <= '1;
            end
        end else if (state == SCAN && e_m) begin
            for (int s = 0; s < K; s++) begin
                if (better[s]) begin
                    if (prev_better[s] && s > 0) begin
                        slot_v[s]  <= slot_v[s-1];
                        slot_i[s]  <= slot_i[s-1];
                        slot_sv[s] <= slot_sv[s-1];
                    end else begin
                        slot_v[s]  <= e_v;
                        slot_i[s]  <= e_i;
                        slot_sv[s] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        out_count = '0;
        for (int s = 0; s < K; s++) out_count = out_count + CW'(slot_sv[s]);
    end

    assign dout           = slot_v;
    assign out_index      = slot_i;
    assign out_slot_valid = slot_sv;

endmodule

// File: tb/tb_topk_select.sv
// Bench for topk_select: table vectors plus random frames through a scoreboard,
// then the backpressure and mid-scan reset sequences.
module tb_topk_select;
    localparam int DW = 32, K = 3, BW = 12, IW = 4;

    typedef struct packed {
        logic [K-1:0][DW-1:0] v;
        logic [K-1:0][IW-1:0] i;
        logic [K-1:0]         sv;
        logic [1:0]           cnt;
    } res_t;

    typedef struct packed {
        logic [BW-1:0][DW-1:0] din;
        logic [BW-1:0]         mask;
        logic                  mode;
        res_t                  exp;
    } vec_t;

    logic clk = 0, rstn = 0, in_valid = 0, mode = 0, out_ready = 0;
    logic in_ready, out_valid, busy;
    logic [DW-1:0] din [BW];
    logic [IW-1:0] index_in [BW];
    logic [BW-1:0] in_mask = '0;
    logic [DW-1:0] dout [K];
    logic [IW-1:0] out_index [K];
    logic [K-1:0]  out_slot_valid;
    logic [1:0]    out_count;

    int checks = 0, failures = 0;
    res_t exp_q[$];
    vec_t tbl[5];

    topk_select #(.DW(DW), .K(K), .BUS_WIDTH(BW), .IW(IW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .din(din), .index_in(index_in), .in_mask(in_mask), .dout(dout),
        .out_index(out_index), .out_slot_valid(out_slot_valid), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic res_t mk(input int v0, i0, v1, i1, v2, i2, input logic [2:0] sv, input int cnt);
        res_t r;
        r.v[0] = v0; r.i[0] = i0[3:0];
        r.v[1] = v1; r.i[1] = i1[3:0];
        r.v[2] = v2; r.i[2] = i2[3:0];
        r.sv = sv; r.cnt = cnt[1:0];
        return r;
    endfunction

    // Reference: repeated best-pick selection with strict compare (earliest wins ties).
    function automatic res_t model(input vec_t t);
        res_t r;
        logic [BW-1:0] used = '0;
        int best;
        r = mk(0, 15, 0, 15, 0, 15, 3'b000, 0);
        for (int s = 0; s < K; s++) begin
            best = -1;
            for (int j = 0; j < BW; j++)
                if (t.mask[j] && !used[j])
                    if (best < 0 || (t.mode ? t.din[j] > t.din[best] : t.din[j] < t.din[best]))
                        best = j;
            if (best >= 0) begin
                used[best] = 1'b1;
                r.v[s] = t.din[best];
                r.i[s] = best[3:0];
                r.sv[s] = 1'b1;
                r.cnt = r.cnt + 2'd1;
            end
        end
        return r;
    endfunction

    task automatic check_out(input string tag, input res_t e);
        for (int s = 0; s < K; s++) begin
            chk($sformatf("%s dout[%0d]", tag, s), 64'(dout[s]), 64'(e.v[s]));
            chk($sformatf("%s out_index[%0d]", tag, s), 64'(out_index[s]), 64'(e.i[s]));
        end
        chk({tag, " out_slot_valid"}, 64'(out_slot_valid), 64'(e.sv));
        chk({tag, " out_count"}, 64'(out_count), 64'(e.cnt));
    endtask

    task automatic drive(input vec_t t);
        for (int i = 0; i < BW; i++) din[i] = t.din[i];
        in_mask = t.mask;
        mode    = t.mode;
    endtask

    task automatic send(input string tag, input vec_t t, input int hold);
        res_t e;
        int n;
        @(negedge clk);
        chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        drive(t);
        in_valid = 1;
        exp_q.push_back(t.exp);
        @(negedge clk);
        in_valid = 0;
        for (int i = 0; i < BW; i++) din[i] = $urandom;
        in_mask = $urandom;
        mode = ~mode;
        chk({tag, " busy in scan"}, 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(BW));
        e = exp_q.pop_front();
        check_out(tag, e);
        for (int h = 0; h < hold; h++) begin
            out_ready = 0;
            in_valid  = 1;
            @(negedge clk);
            chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold dout[0]"}, 64'(dout[0]), 64'(e.v[0]));
        end
        in_valid  = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({tag, " post out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " post in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int c1[BW] = '{10, 50, 20, 50, 5, 40, 7, 30, 60, 15, 25, 35};
        vec_t rv;
        for (int i = 0; i < BW; i++) begin
            index_in[i] = i[IW-1:0];
            din[i] = '0;
        end
        for (int c = 0; c < 5; c++)
            for (int i = 0; i < BW; i++) tbl[c].din[i] = (c == 3) ? 7 : c1[i];
        tbl[0].mask = 12'hFFF; tbl[0].mode = 1; tbl[0].exp = mk(60, 8, 50, 1, 50, 3, 3'b111, 3);
        tbl[1].mask = 12'hFFF; tbl[1].mode = 0; tbl[1].exp = mk(5, 4, 7, 6, 10, 0, 3'b111, 3);
        tbl[2].mask = 12'h005; tbl[2].mode = 1; tbl[2].exp = mk(20, 2, 10, 0, 0, 15, 3'b011, 2);
        tbl[3].mask = 12'hFFF; tbl[3].mode = 1; tbl[3].exp = mk(7, 0, 7, 1, 7, 2, 3'b111, 3);
        tbl[4].mask = 12'h000; tbl[4].mode = 0; tbl[4].exp = mk(0, 15, 0, 15, 0, 15, 3'b000, 0);

        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1;
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        check_out("reset", mk(0, 15, 0, 15, 0, 15, 3'b000, 0));

        for (int c = 0; c < 5; c++) send($sformatf("case%0d", c + 1), tbl[c], 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < BW; i++) rv.din[i] = $urandom_range(0, 15);
            rv.mask = (r == 5) ? 12'h001 : $urandom;
            rv.mode = r[0];
            rv.exp  = model(rv);
            send($sformatf("rand%0d", r), rv, 0);
        end

        send("backpressure", tbl[1], 5);
        send("after_bp", tbl[0], 0);

        @(negedge clk);
        drive(tbl[0]);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (6) @(negedge clk);
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset in_ready", 64'(in_ready), 64'd1);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset out_slot_valid", 64'(out_slot_valid), 64'd0);
        send("resend", tbl[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/topk_select.md
# topk_select

Parametrised top-K selector. Accepts one frame of BUS_WIDTH tagged samples in parallel through a valid/ready handshake and serialises it internally into a K-slot insertion-sort register chain. Returns the K smallest or K largest entries, sorted, with their source indices. It supersedes the fixed-mode min/max chains in the localizer datapath, adding a runtime mode, a per-element mask, deterministic tie-breaking and output backpressure.

## Interface
- DW, 32, sample width (unsigned)
- K, 3, number of result slots; 1 ≤ K ≤ BUS_WIDTH
- BUS_WIDTH, 12, samples per frame; ≥ 2
- IW, 4, index tag width; IW ≥ $clog2(BUS_WIDTH)

Ports:
- clk  in  1  clock; all logic on posedge
- rstn  in  1  reset; one clock, synchronous, active-low
- in_valid  in  1  frame valid
- in_ready  out  1  frame accepted when in_valid & in_ready
- mode  in  1  0 = select K minimum, 1 = select K maximum; sampled at accept
- din  in  DW×BUS_WIDTH  unpacked sample array
- index_in  in  IW×BUS_WIDTH  unpacked index tags
- in_mask  in  BUS_WIDTH  1 = element participates; sampled at accept
- dout  out  DW×K  result values; slot 0 is best
- out_index  out  IW×K  result tags
- out_slot_valid  out  K  per-slot occupancy
- out_count  out  $clog2(K+1)  number of occupied slots
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- busy  out  1  high in SCAN and DONE

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready = 1. On accept:
  - latch din, index_in, in_mask and mode into a shadow register;
  - clear all slots;
  - set element counter j = 0;
  - go to SCAN.
- SCAN: one element per cycle, j = 0..BUS_WIDTH-1. Masked-off elements are skipped without changing the slots but still take their cycle. After j = BUS_WIDTH-1, go to DONE.
- Insertion of element e:
  - e is "better" than slot s if s is empty, or e.v < s.v (mode 0), or e.v > s.v (mode 1).
  - p = lowest slot where e is better. Slots p..K-2 shift to p+1..K-1, the old slot K-1 is dropped, and e is written to p.
  - If no such p exists, e is discarded.
  - Equal values are never "better", so on a tie the lower j (earlier element) ranks first.
- Comparison is unsigned, DW bits. Index tags are carried opaquely and are not checked for uniqueness.
- DONE:
  - out_valid = 1; dout, out_index, out_slot_valid and out_count are stable.
  - On out_valid & out_ready, go to IDLE.
- Empty slots drive dout = 0, out_index = all ones and out_slot_valid = 0. out_count = min(popcount(in_mask), K).
- in_ready = (state == IDLE). in_valid is ignored in SCAN and DONE.
- rstn low at any clock edge, including mid-SCAN or mid-DONE, forces IDLE and clears all slots. The in-flight frame is lost, and no partial result is emitted.

## Timing
- Accept at edge T0. SCAN covers edges T1..T_BUS_WIDTH. out_valid rises after edge T_BUS_WIDTH, so it is high in cycle BUS_WIDTH+1 counted from the accept cycle.
- Accept-to-result latency is BUS_WIDTH+1 cycles. This is independent of K and of in_mask.
- out_valid stays high until the handshake. in_ready rises the cycle after the handshake.
- Maximum frame rate is one frame per BUS_WIDTH+2 cycles. No overlap between frames.
- Values after reset:
  - state = IDLE, so in_ready = 1 in the first cycle with rstn high;
  - out_valid = 0, busy = 0, out_count = 0;
  - out_slot_valid = 0, dout = 0, out_index = all ones.
- Result outputs hold their last value in IDLE. They are meaningful only while out_valid = 1.
- Input arrays need to be valid only in the accept cycle.

## Test plan
Defaults: DW=32, K=3, BUS_WIDTH=12, IW=4, index_in[i] = i.

1. mode=1, mask all ones, din = 10,50,20,50,5,40,7,30,60,15,25,35 -> out_valid in cycle 13; slots = (60,8),(50,1),(50,3); out_count = 3.
2. Same din, mode=0 -> slots = (5,4),(7,6),(10,0).
3. mode=1, in_mask = 12'h005, same din -> slots = (20,2),(10,0), then slot 2 empty (0,4'hF); out_slot_valid = 3'b011; out_count = 2.
4. All din = 7, mode=1 -> slots = indices 0,1,2 in that order (tie rule).
5. Hold out_ready = 0 for 5 cycles after out_valid, and pulse in_valid meanwhile -> outputs stable, in_ready = 0, no accept; then assert out_ready -> in_ready = 1 the next cycle and the next frame is processed correctly.
6. Drop rstn for one cycle at SCAN element j = 6 -> next cycle state IDLE, out_valid = 0, in_ready = 1; re-send case 1 -> identical result at latency 13.
